// File: rtl/nr_div_pkg.sv
// Shared types and sizing helpers for the nr_div_unit non-restoring divider.
package nr_div_pkg;

   typedef enum logic [1:0] {
      OP_DIV  = 2'b00,
      OP_DIVU = 2'b01,
      OP_REM  = 2'b10,
      OP_REMU = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DIVIDE,
      ST_RESTORE,
      ST_DONE
   } state_e;

   function automatic int unsigned cnt_width(input int unsigned xlen);
      return $clog2(xlen) + 1;
   endfunction

   localparam int unsigned XLEN_DEFAULT = 32;
   localparam int unsigned CNT_W        = cnt_width(XLEN_DEFAULT);

endpackage

// File: rtl/nr_div_unit_if.sv
// Request/response handshake bundle of the divider; names are relative to the unit.
interface nr_div_unit_if #(
   parameter int unsigned XLEN = 32
);
   logic            valid_i;
   logic            ready_o;
   logic [1:0]      op_i;
   logic [XLEN-1:0] dividend_i;
   logic [XLEN-1:0] divisor_i;
   logic            valid_o;
   logic            ready_i;
   logic [XLEN-1:0] result_o;
   logic            div_by_zero_o;
   logic            overflow_o;

   modport master (
      output valid_i, op_i, dividend_i, divisor_i, ready_i,
      input  ready_o, valid_o, result_o, div_by_zero_o, overflow_o
   );

   modport slave (
      input  valid_i, op_i, dividend_i, divisor_i, ready_i,
      output ready_o, valid_o, result_o, div_by_zero_o, overflow_o
   );
endinterface

// File: rtl/div_lzc.sv
// Combinational leading-zero counter; an all-zero input yields WIDTH.
module div_lzc
   import nr_div_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0]            data,
   output logic [cnt_width(WIDTH)-1:0] count
);
   localparam int unsigned CW = cnt_width(WIDTH);

   // Scanning upward lets the most significant set bit win.
   always_comb begin
      count = CW'(WIDTH);
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (data[i]) count = CW'(WIDTH - 1 - i);
      end
   end
endmodule

// File: rtl/nr_div_unit.sv
// Multi-cycle non-restoring divider for DIV/DIVU/REM/REMU with RISC-V special cases.
// Define NR_DIV_EARLY_TERM_EN to skip leading zeros of the dividend magnitude.
module nr_div_unit
   import nr_div_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         clk_en_i,
   nr_div_unit_if.slave bus
);
   localparam int unsigned   CW       = cnt_width(XLEN);
   localparam logic [CW-1:0] LAST_CNT = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   state_e          state;
   op_e             op_q;
   logic [XLEN:0]   rem;
   logic [XLEN-1:0] quo;
   logic [XLEN-1:0] dvsr;
   logic [XLEN-1:0] result;
   logic [CW-1:0]   cnt;
   logic            q_neg;
   logic            r_neg;
   logic            valid;
   logic            dbz;
   logic            ovf;

   op_e             op_in;
   logic            signed_in;
   logic            a_neg;
   logic            b_neg;
   logic [XLEN-1:0] a_mag;
   logic [XLEN-1:0] b_mag;
   logic            div_zero;
   logic            sgn_ovf;
   logic            zero_dvd;
   logic [XLEN-1:0] quo_init;
   logic [CW-1:0]   cnt_init;

   logic [XLEN:0]   rem_sh;
   logic [XLEN:0]   rem_step;
   logic [XLEN:0]   rem_fix;
   logic [XLEN-1:0] q_final;
   logic [XLEN-1:0] r_final;

   always_comb begin
      op_in     = op_e'(bus.op_i);
      signed_in = (op_in == OP_DIV) || (op_in == OP_REM);
      a_neg     = signed_in & bus.dividend_i[XLEN-1];
      b_neg     = signed_in & bus.divisor_i[XLEN-1];
      a_mag     = a_neg ? -bus.dividend_i : bus.dividend_i;
      b_mag     = b_neg ? -bus.divisor_i  : bus.divisor_i;
      div_zero  = (bus.divisor_i == '0);
      sgn_ovf   = signed_in && (bus.dividend_i == MIN_NEG) && (bus.divisor_i == '1);
   end

`ifdef NR_DIV_EARLY_TERM_EN
   logic [CW-1:0] lz;

   div_lzc #(.WIDTH(XLEN)) u_lzc (
      .data  (a_mag),
      .count (lz)
   );

   // Skipped high bits would only contribute zero quotient bits and leave rem at 0.
   always_comb begin
      quo_init = a_mag << lz;
      cnt_init = LAST_CNT - lz;
      zero_dvd = (a_mag == '0);
   end
`else
   always_comb begin
      quo_init = a_mag;
      cnt_init = LAST_CNT;
      zero_dvd = 1'b0;
   end
`endif

   // Partial remainder stays in [-D, D); the dropped top bit of the shift is modular.
   always_comb begin
      rem_sh   = {rem[XLEN-1:0], quo[XLEN-1]};
      rem_step = rem[XLEN] ? (rem_sh + {1'b0, dvsr}) : (rem_sh - {1'b0, dvsr});
      rem_fix  = rem[XLEN] ? (rem + {1'b0, dvsr}) : rem;
      q_final  = q_neg ? -quo : quo;
      r_final  = r_neg ? -rem_fix[XLEN-1:0] : rem_fix[XLEN-1:0];
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state  <= ST_IDLE;
         op_q   <= OP_DIV;
         rem    <= '0;
         quo    <= '0;
         dvsr   <= '0;
         cnt    <= '0;
         q_neg  <= 1'b0;
         r_neg  <= 1'b0;
         result <= '0;
         valid  <= 1'b0;
         dbz    <= 1'b0;
         ovf    <= 1'b0;
      end else if (clk_en_i) begin
         case (state)
            ST_IDLE: begin
               if (bus.valid_i) begin
                  op_q  <= op_in;
                  q_neg <= a_neg ^ b_neg;
                  r_neg <= a_neg;
                  dvsr  <= b_mag;
                  rem   <= '0;
                  quo   <= quo_init;
                  cnt   <= cnt_init;
                  if (div_zero) begin
                     result <= op_in[1] ? bus.dividend_i : '1;
                     dbz    <= 1'b1;
                     ovf    <= 1'b0;
                     valid  <= 1'b1;
                     state  <= ST_DONE;
                  end else if (sgn_ovf) begin
                     result <= op_in[1] ? '0 : bus.dividend_i;
                     dbz    <= 1'b0;
                     ovf    <= 1'b1;
                     valid  <= 1'b1;
                     state  <= ST_DONE;
                  end else if (zero_dvd) begin
                     result <= '0;
                     dbz    <= 1'b0;
                     ovf    <= 1'b0;
                     valid  <= 1'b1;
                     state  <= ST_DONE;
                  end else begin
                     state <= ST_DIVIDE;
                  end
               end
            end
            ST_DIVIDE: begin
               rem <= rem_step;
               quo <= {quo[XLEN-2:0], ~rem_step[XLEN]};
               cnt <= cnt - CW'(1);
               if (cnt == '0) state <= ST_RESTORE;
            end
            ST_RESTORE: begin
               result <= ((op_q == OP_REM) || (op_q == OP_REMU)) ? r_final : q_final;
               dbz    <= 1'b0;
               ovf    <= 1'b0;
               valid  <= 1'b1;
               state  <= ST_DONE;
            end
            ST_DONE: begin
               if (bus.ready_i) begin
                  valid <= 1'b0;
                  dbz   <= 1'b0;
                  ovf   <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.ready_o       = (state == ST_IDLE);
   assign bus.valid_o       = valid;
   assign bus.result_o      = result;
   assign bus.div_by_zero_o = dbz;
   assign bus.overflow_o    = ovf;
endmodule

// File: tb/tb_nr_div_unit.sv
// Self-checking bench for nr_div_unit: directed RISC-V cases plus random ops against an arithmetic model.
module tb_nr_div_unit;
   localparam int unsigned XLEN = 32;
   localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;
   localparam logic [XLEN-1:0] MIN_NEG = 32'h8000_0000;

   logic clk;
   logic rst_n;
   logic clk_en;
   int   n_checks;
   int   n_errors;

   nr_div_unit_if #(.XLEN(XLEN)) bus ();

   nr_div_unit #(.XLEN(XLEN)) dut (
      .clk_i    (clk),
      .rst_n_i  (rst_n),
      .clk_en_i (clk_en),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic void ref_div(input logic [1:0] op, input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b, output logic [XLEN-1:0] res,
                                   output logic dbz, output logic ovf);
      longint          sa, sb;
      longint unsigned ua, ub;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = longint'(a);
      ub  = longint'(b);
      dbz = (b == '0);
      ovf = !op[0] && (a == MIN_NEG) && (b == '1);
      if (dbz)        res = op[1] ? a : '1;
      else if (ovf)   res = op[1] ? '0 : a;
      else if (op[0]) res = op[1] ? XLEN'(ua % ub) : XLEN'(ua / ub);
      else            res = op[1] ? XLEN'(sa % sb) : XLEN'(sa / sb);
   endfunction

   function automatic int exp_lat(input logic [1:0] op, input logic [XLEN-1:0] a,
                                  input logic [XLEN-1:0] b);
      logic [XLEN-1:0] mag;
      int              bits;
      if (b == '0) return 1;
      if (!op[0] && (a == MIN_NEG) && (b == '1)) return 1;
      mag  = (!op[0] && a[XLEN-1]) ? -a : a;
      bits = 0;
      while (mag != '0) begin
         mag = mag >> 1;
         bits++;
      end
`ifdef NR_DIV_EARLY_TERM_EN
      if (bits == 0) return 1;
      return bits + 2;
`else
      return int'(XLEN) + 2;
`endif
   endfunction

   task automatic issue(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      int guard = 0;
      while (!bus.ready_o && guard < 400) begin
         @(posedge clk);
         #1;
         guard++;
      end
      check("ready_wait", {63'd0, bus.ready_o}, 64'd1);
      bus.valid_i    = 1'b1;
      bus.op_i       = op;
      bus.dividend_i = a;
      bus.divisor_i  = b;
      @(posedge clk);
      #1;
      bus.valid_i    = 1'b0;
      bus.op_i       = 2'($urandom);
      bus.dividend_i = $urandom;
      bus.divisor_i  = $urandom;
   endtask

   task automatic collect(input string tag, input logic [1:0] op, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input int extra, input int lat0);
      int              lat;
      logic [XLEN-1:0] er;
      logic            ed, eo;
      lat = lat0;
      while (!bus.valid_o && lat < 400) begin
         @(posedge clk);
         #1;
         lat++;
      end
      ref_div(op, a, b, er, ed, eo);
      check({tag, "_lat"}, 64'(lat), 64'(exp_lat(op, a, b) + extra));
      check({tag, "_res"}, 64'(bus.result_o), 64'(er));
      check({tag, "_dbz"}, {63'd0, bus.div_by_zero_o}, {63'd0, ed});
      check({tag, "_ovf"}, {63'd0, bus.overflow_o}, {63'd0, eo});
   endtask

   task automatic do_op(input string tag, input logic [1:0] op, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b);
      issue(op, a, b);
      collect(tag, op, a, b, 0, 1);
      @(posedge clk);
      #1;
      check({tag, "_vdrop"}, {63'd0, bus.valid_o}, 64'd0);
   endtask

   initial begin
      logic [1:0]      rop;
      logic [XLEN-1:0] ra, rb;
      n_checks       = 0;
      n_errors       = 0;
      rst_n          = 1'b0;
      clk_en         = 1'b1;
      bus.valid_i    = 1'b0;
      bus.op_i       = 2'b00;
      bus.dividend_i = '0;
      bus.divisor_i  = '0;
      bus.ready_i    = 1'b1;
      #1;
      check("rst_result", 64'(bus.result_o), 64'd0);
      check("rst_valid", {63'd0, bus.valid_o}, 64'd0);
      check("rst_ready", {63'd0, bus.ready_o}, 64'd1);
      check("rst_dbz", {63'd0, bus.div_by_zero_o}, 64'd0);
      check("rst_ovf", {63'd0, bus.overflow_o}, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      do_op("divu_100_7", DIVU, 100, 7);
      do_op("remu_100_7", REMU, 100, 7);
      do_op("div_m7_2", DIV, 32'hFFFF_FFF9, 2);
      do_op("rem_m7_2", REM, 32'hFFFF_FFF9, 2);
      do_op("rem_7_m2", REM, 7, 32'hFFFF_FFFE);
      do_op("divu_5_0", DIVU, 5, 0);
      do_op("remu_5_0", REMU, 5, 0);
      do_op("div_5_0", DIV, 5, 0);
      do_op("div_ovf", DIV, MIN_NEG, 32'hFFFF_FFFF);
      do_op("rem_ovf", REM, MIN_NEG, 32'hFFFF_FFFF);
      do_op("divu_noovf", DIVU, MIN_NEG, 32'hFFFF_FFFF);
      do_op("divu_9_3", DIVU, 9, 3);
      do_op("divu_0_9", DIVU, 0, 9);
      do_op("div_min_1", DIV, MIN_NEG, 1);
      do_op("remu_max_max", REMU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      do_op("divu_max_1", DIVU, 32'hFFFF_FFFF, 1);

      // Back-pressure with a competing request held on valid_i.
      bus.ready_i = 1'b0;
      issue(DIVU, 100, 7);
      collect("bp", DIVU, 100, 7, 0, 1);
      bus.valid_i    = 1'b1;
      bus.op_i       = DIVU;
      bus.dividend_i = 50;
      bus.divisor_i  = 5;
      repeat (5) begin
         @(posedge clk);
         #1;
         check("bp_hold_res", 64'(bus.result_o), 64'd14);
         check("bp_hold_valid", {63'd0, bus.valid_o}, 64'd1);
         check("bp_ready_low", {63'd0, bus.ready_o}, 64'd0);
      end
      bus.ready_i = 1'b1;
      @(posedge clk);
      #1;
      check("bp_idle", {63'd0, bus.ready_o}, 64'd1);
      check("bp_vdrop", {63'd0, bus.valid_o}, 64'd0);
      @(posedge clk);
      #1;
      bus.valid_i = 1'b0;
      check("bp_accept", {63'd0, bus.ready_o}, 64'd0);
      collect("bp_next", DIVU, 50, 5, 0, 1);
      @(posedge clk);
      #1;

      // Reset in the middle of a division.
      issue(DIVU, 32'hDEAD_BEEF, 13);
      repeat (9) begin
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", {63'd0, bus.valid_o}, 64'd0);
      check("mid_rst_ready", {63'd0, bus.ready_o}, 64'd1);
      check("mid_rst_result", 64'(bus.result_o), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      do_op("after_rst", DIVU, 32'hDEAD_BEEF, 13);

      // Clock-enable stall mid-division.
      issue(DIV, 32'hFFFF_FFF9, 2);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      clk_en = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      clk_en = 1'b1;
      collect("clken", DIV, 32'hFFFF_FFF9, 2, 3, 6);
      @(posedge clk);
      #1;

      for (int i = 0; i < 60; i++) begin
         rop = 2'($urandom);
         case ($urandom_range(0, 5))
            0: begin ra = $urandom; rb = 0; end
            1: begin ra = MIN_NEG; rb = 32'hFFFF_FFFF; end
            2: begin ra = $urandom_range(0, 1000); rb = $urandom_range(1, 50); end
            3: begin ra = $urandom; rb = $urandom_range(1, 7) - 4; end
            4: begin ra = $urandom >> $urandom_range(0, 31); rb = $urandom >> $urandom_range(0, 31); end
            default: begin ra = $urandom; rb = $urandom; end
         endcase
         do_op("rand", rop, ra, rb);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end
endmodule

// File: doc/nr_div_unit.md
# nr_div_unit

Parametrised, multi-cycle non-restoring integer divider for the RISC-V M-extension execute stage. It executes DIV, DIVU, REM and REMU on XLEN-bit operands. Special cases follow RISC-V rules: divide-by-zero and signed overflow. Operands arrive and results leave over valid/ready handshakes. It replaces the fixed-width unsigned divider and adds signed operation, back-pressure, and optional leading-zero early termination.

## Interface
- XLEN, 32, operand/result width (≥8, power of two)
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- clk_en_i  in  1  clock enable; when low every register holds
- valid_i  in  1  request valid
- ready_o  out  1  unit can accept a request (high only in IDLE)
- op_i  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- dividend_i  in  XLEN  rs1 value
- divisor_i  in  XLEN  rs2 value
- valid_o  out  1  result valid
- ready_i  in  1  consumer accepts result
- result_o  out  XLEN  quotient (DIV/DIVU) or remainder (REM/REMU)
- div_by_zero_o  out  1  divisor was zero (qualified by valid_o)
- overflow_o  out  1  signed overflow case (qualified by valid_o)

## Operation
- **Accept:** when valid_i && ready_o && clk_en_i. Operands and op are captured. Later input changes are ignored.
- **States:**
  - IDLE → DIVIDE on accept.
  - IDLE → DONE directly on a special case.
  - DIVIDE → RESTORE when the iteration counter reaches its last count.
  - RESTORE → DONE.
  - DONE → IDLE when ready_i is high.
- **Operand preparation (signed ops):** magnitudes are taken. Quotient sign = sign(dividend) XOR sign(divisor). Remainder sign = sign(dividend).
- **Divide by zero:** divisor == 0.
  - DIV/DIVU result = all-ones.
  - REM/REMU result = dividend.
  - div_by_zero_o = 1.
- **Signed overflow:** DIV/REM with dividend = 1 followed by zeros (most negative) and divisor = all-ones.
  - DIV result = dividend.
  - REM result = 0.
  - overflow_o = 1.
  - Not flagged for DIVU/REMU.
- **DIVIDE (one step per cycle):**
  - Datapath: XLEN+1-bit signed partial remainder plus XLEN-bit quotient register.
  - Each cycle, shift {rem, quo} left by 1.
  - If the remainder is negative, add the divisor; otherwise subtract it.
  - Quotient LSB = ~sign of the new remainder.
- **RESTORE:**
  - If the remainder is negative, add the divisor back.
  - Apply sign correction: two's-complement negate the quotient/remainder per the signs above.
  - Select the quotient or remainder by op and register it into result_o.
- **Output hold:** result_o and flags are held stable while valid_o && !ready_i.
- **Reset:**
  - Outputs: result_o = 0, valid_o = 0, ready_o = 1, div_by_zero_o = 0, overflow_o = 0.
  - State = IDLE.
  - Asserting reset mid-operation aborts the division; no valid_o is produced.

## Timing
- Counts are in enabled clock cycles. Accept edge = cycle 0.
- Normal path: DIVIDE for N cycles, RESTORE for 1, DONE. valid_o rises N+2 cycles after accept.
  - N = XLEN without the macro.
- Special cases: valid_o rises 1 cycle after accept.
- ready_o is low from the accept edge until the cycle after DONE is consumed.
  - No accept occurs in the same cycle as result consumption.
  - Minimum initiation interval = latency + 1.
- ready_o is combinational from state only. No combinational path from valid_i or ready_i to any output.

## Configuration
- `NR_DIV_EARLY_TERM_EN` defined:
  - At accept, count leading zeros (lz) of |dividend|.
  - Pre-shift the quotient register by lz and set N = XLEN − lz.
  - A zero dividend (non-zero divisor) goes straight to DONE with result 0 (latency 1).
- Not defined:
  - N is fixed at XLEN.
  - The leading-zero counter is absent.
  - Results are identical in both configurations; only latency differs.

## Structure
- Package `nr_div_pkg`:
  - op encoding enum (DIV/DIVU/REM/REMU)
  - FSM state enum (IDLE, DIVIDE, RESTORE, DONE)
  - counter width localparam, $clog2(XLEN)+1
- Sub-module `div_lzc` (parametrised leading-zero counter over XLEN, purely combinational).
  - Instantiated only under `NR_DIV_EARLY_TERM_EN`.
  - Replaces any hand-written priority case.

## Test plan
- DIVU 100/7, XLEN=32, no macro → result 14, valid_o exactly 34 cycles after accept. REMU 100/7 → 2.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD (−3). REM → 0xFFFFFFFF (−1). REM 7/−2 → 1.
- DIVU 5/0 → 0xFFFFFFFF with div_by_zero_o=1. REMU 5/0 → 5. Both have valid_o 1 cycle after accept.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 with overflow_o=1. REM → 0. DIVU with the same operands → 0, overflow_o=0.
- Back-pressure:
  - Hold ready_i low for 5 cycles after valid_o → result_o stable, ready_o low, the extra valid_i is not accepted.
  - Raise ready_i → IDLE next cycle, then the next request is accepted.
- Macro defined: DIVU 9/3 → 3 with valid_o 6 cycles after accept; 0/9 → 0 after 1 cycle.
- Reset asserted at cycle 10 of a division → valid_o = 0, ready_o = 1, and the next request completes correctly.
- clk_en_i low for 3 cycles mid-division → latency extends by exactly 3, and the result is unchanged.
